// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 UART receiver feeding a MIDI note-on/off parser that maintains a held-key bitmap.
module midi_uart_rx #(
    parameter int         CLKS_PER_BIT   = 3200,
    parameter int         NUM_KEYS       = 88,
    parameter int         LOWEST_NOTE    = 21,
    parameter bit         CHAN_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL        = 4'd0
) (
    input  logic                clk_100mhz,
    input  logic                reset,
    input  logic                rx_in,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    output logic                frame_err,
    output logic                note_valid,
    output logic [6:0]          note_num,
    output logic                note_on,
    output logic [6:0]          velocity,
    output logic [NUM_KEYS-1:0] keys,
    output logic [7:0]          key_count,
    output logic [6:0]          low_key
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_M1 = 12'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  LO8     = 8'(LOWEST_NOTE);
    localparam logic [7:0]  KEYS8   = 8'(NUM_KEYS);
    state_t        r_state, w_state_nxt;
    logic          r_rx_meta, r_rx_s, r_armed;
    logic [11:0]   r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_rs_valid, r_rs_on, r_phase;
    logic [6:0]    r_note_lat;
    logic          w_half, w_full, w_status_ok, w_on, w_in_range;
    logic [7:0]    w_idx, w_count;
    logic [6:0]    w_low;
    logic [NUM_KEYS-1:0] w_mask;
    assign w_half = r_timer == HALF_M1;
    assign w_full = r_timer == FULL_M1;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (!r_rx_s && r_armed) ? S_START : S_IDLE;
            S_START: w_state_nxt = w_half ? (r_rx_s ? S_IDLE : S_DATA) : S_START;
            S_DATA:  w_state_nxt = (w_full && r_bit_idx == 3'd7) ? S_STOP : S_DATA;
            S_STOP:  w_state_nxt = w_full ? S_IDLE : S_STOP;
            default: w_state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_armed    <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_rx_meta  <= rx_in;
            r_rx_s     <= r_rx_meta;
            r_state    <= w_state_nxt;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            r_timer    <= (r_state == S_IDLE || w_state_nxt != r_state || (r_state == S_DATA && w_full)) ?
                          '0 : r_timer + 12'd1;
            // armed only re-arms once the line has been seen high, so a held break cannot retrigger
            if (r_state == S_IDLE)
                r_armed <= (w_state_nxt == S_START) ? 1'b0 : (r_armed | r_rx_s);
            if (r_state == S_START)
                r_bit_idx <= '0;
            if (r_state == S_DATA && w_full) begin
                r_shift   <= {r_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == S_STOP && w_full) begin
                if (r_rx_s) begin
                    byte_out   <= r_shift;
                    byte_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end
    assign w_status_ok = (byte_out[7:5] == 3'b100) && (!CHAN_FILTER_EN || byte_out[3:0] == CHANNEL);
    assign w_on        = r_rs_on && (byte_out[6:0] != 7'd0);
    assign w_idx       = {1'b0, r_note_lat} - LO8;
    assign w_in_range  = ({1'b0, r_note_lat} >= LO8) && (w_idx < KEYS8);
    assign w_mask      = w_in_range ? (NUM_KEYS'(1) << w_idx) : '0;
    always_comb begin
        w_count = '0;
        w_low   = 7'h7F;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            w_count = w_count + 8'(keys[k]);
            w_low   = keys[k] ? 7'(k) : w_low;
        end
    end
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_rs_valid <= 1'b0;
            r_rs_on    <= 1'b0;
            r_phase    <= 1'b0;
            r_note_lat <= '0;
            note_valid <= 1'b0;
            note_num   <= '0;
            note_on    <= 1'b0;
            velocity   <= '0;
            keys       <= '0;
            key_count  <= '0;
            low_key    <= 7'h7F;
        end else begin
            note_valid <= 1'b0;
            key_count  <= w_count;
            low_key    <= w_low;
            // real-time bytes may appear anywhere and must not disturb running status
            if (byte_valid && byte_out < 8'hF8) begin
                if (byte_out[7]) begin
                    r_rs_valid <= w_status_ok;
                    r_rs_on    <= byte_out[4];
                    r_phase    <= 1'b0;
                end else if (r_rs_valid) begin
                    if (!r_phase) begin
                        r_note_lat <= byte_out[6:0];
                        r_phase    <= 1'b1;
                    end else begin
                        note_valid <= 1'b1;
                        note_num   <= r_note_lat;
                        velocity   <= byte_out[6:0];
                        note_on    <= w_on;
                        r_phase    <= 1'b0;
                        keys       <= w_on ? (keys | w_mask) : (keys & ~w_mask);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: directed MIDI byte streams with queued expectations checked by monitors.
module tb_midi_uart_rx;
    localparam int CPB = 32;
    typedef struct {
        logic [6:0]  num;
        logic        on;
        logic [6:0]  vel;
        logic [87:0] keys;
        logic [7:0]  cnt;
        logic [6:0]  low;
    } ev_t;
    logic clk = 1'b0, reset = 1'b1, rx_a = 1'b1, rx_b = 1'b1;
    logic [7:0]  a_byte_out, b_byte_out, a_key_count, b_key_count;
    logic        a_byte_valid, b_byte_valid, a_frame_err, b_frame_err;
    logic        a_note_valid, b_note_valid, a_note_on, b_note_on;
    logic [6:0]  a_note_num, b_note_num, a_velocity, b_velocity, a_low_key, b_low_key;
    logic [87:0] a_keys, b_keys;
    int n_checks = 0, n_fail = 0, fe_a = 0;
    logic [7:0] q_byte_a[$];
    ev_t q_ev_a[$], q_ev_b[$];
    logic pend_a = 1'b0, pend_b = 1'b0;
    logic [7:0] pc_a, pc_b;
    logic [6:0] pl_a, pl_b;
    midi_uart_rx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk_100mhz(clk), .reset(reset), .rx_in(rx_a),
        .byte_out(a_byte_out), .byte_valid(a_byte_valid), .frame_err(a_frame_err),
        .note_valid(a_note_valid), .note_num(a_note_num), .note_on(a_note_on), .velocity(a_velocity),
        .keys(a_keys), .key_count(a_key_count), .low_key(a_low_key));
    midi_uart_rx #(.CLKS_PER_BIT(CPB), .CHAN_FILTER_EN(1'b1), .CHANNEL(4'd2)) dut_b (
        .clk_100mhz(clk), .reset(reset), .rx_in(rx_b),
        .byte_out(b_byte_out), .byte_valid(b_byte_valid), .frame_err(b_frame_err),
        .note_valid(b_note_valid), .note_num(b_note_num), .note_on(b_note_on), .velocity(b_velocity),
        .keys(b_keys), .key_count(b_key_count), .low_key(b_low_key));
    always #5 clk = ~clk;
    function automatic logic [87:0] k(input int i);
        return 88'(1) << i;
    endfunction
    task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic unexp(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: strobe with nothing expected", nm);
    endtask
    always @(negedge clk) begin
        if (pend_a) begin
            chk("key_count_a", 88'(a_key_count), 88'(pc_a));
            chk("low_key_a", 88'(a_low_key), 88'(pl_a));
            pend_a = 1'b0;
        end
        if (a_byte_valid) begin
            if (q_byte_a.size() == 0) unexp("byte_valid_a");
            else chk("byte_a", 88'(a_byte_out), 88'(q_byte_a.pop_front()));
        end
        if (a_frame_err) begin
            if (fe_a == 0) unexp("frame_err_a");
            else begin
                fe_a--;
                chk("frame_err_a", 88'(a_frame_err), 88'(1));
            end
        end
        if (b_frame_err) unexp("frame_err_b");
        if (a_note_valid) begin
            if (q_ev_a.size() == 0) unexp("note_valid_a");
            else begin
                ev_t e;
                e = q_ev_a.pop_front();
                chk("note_num_a", 88'(a_note_num), 88'(e.num));
                chk("note_on_a", 88'(a_note_on), 88'(e.on));
                chk("velocity_a", 88'(a_velocity), 88'(e.vel));
                chk("keys_a", a_keys, e.keys);
                pc_a = e.cnt;
                pl_a = e.low;
                pend_a = 1'b1;
            end
        end
    end
    always @(negedge clk) begin
        if (pend_b) begin
            chk("key_count_b", 88'(b_key_count), 88'(pc_b));
            chk("low_key_b", 88'(b_low_key), 88'(pl_b));
            pend_b = 1'b0;
        end
        if (b_note_valid) begin
            if (q_ev_b.size() == 0) unexp("note_valid_b");
            else begin
                ev_t e;
                e = q_ev_b.pop_front();
                chk("note_num_b", 88'(b_note_num), 88'(e.num));
                chk("note_on_b", 88'(b_note_on), 88'(e.on));
                chk("velocity_b", 88'(b_velocity), 88'(e.vel));
                chk("keys_b", b_keys, e.keys);
                pc_b = e.cnt;
                pl_b = e.low;
                pend_b = 1'b1;
            end
        end
    end
    task automatic line(input bit which, input logic v, input int cycles);
        if (which) rx_b = v;
        else rx_a = v;
        repeat (cycles) @(negedge clk);
    endtask
    task automatic frame(input bit which, input logic [7:0] b, input logic stop);
        line(which, 1'b0, CPB);
        for (int i = 0; i < 8; i++) line(which, b[i], CPB);
        line(which, stop, CPB);
    endtask
    task automatic send(input bit which, input logic [7:0] b);
        if (!which) q_byte_a.push_back(b);
        frame(which, b, 1'b1);
        line(which, 1'b1, 2 * CPB);
    endtask
    task automatic ev(input bit which, input logic [6:0] num, input logic on, input logic [6:0] vel,
                      input logic [87:0] ks, input logic [7:0] cnt, input logic [6:0] low);
        ev_t e;
        e = '{num: num, on: on, vel: vel, keys: ks, cnt: cnt, low: low};
        if (which) q_ev_b.push_back(e);
        else q_ev_a.push_back(e);
    endtask
    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_byte_out", 88'(a_byte_out), 88'(0));
        chk("rst_keys", a_keys, 88'(0));
        chk("rst_key_count", 88'(a_key_count), 88'(0));
        chk("rst_low_key", 88'(a_low_key), 88'(7'h7F));
        chk("rst_note", 88'({a_note_num, a_note_on, a_velocity}), 88'(0));
        line(0, 1'b1, 2 * CPB);
        ev(0, 7'd60, 1'b1, 7'd100, k(39), 8'd1, 7'd39);
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
        ev(0, 7'd60, 1'b1, 7'd64, k(39), 8'd1, 7'd39);
        ev(0, 7'd64, 1'b0, 7'd0, k(39), 8'd1, 7'd39);
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'h40); send(0, 8'h40); send(0, 8'h00);
        ev(0, 7'd60, 1'b1, 7'd80, k(39), 8'd1, 7'd39);
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'hF8); send(0, 8'h50);
        ev(0, 7'd60, 1'b0, 7'd0, 88'(0), 8'd0, 7'h7F);
        send(0, 8'h80); send(0, 8'h3C); send(0, 8'h00);
        ev(0, 7'd21, 1'b1, 7'd127, k(0), 8'd1, 7'd0);
        ev(0, 7'd108, 1'b1, 7'd1, k(0) | k(87), 8'd2, 7'd0);
        ev(0, 7'd127, 1'b1, 7'd16, k(0) | k(87), 8'd2, 7'd0);
        send(0, 8'h90); send(0, 8'h15); send(0, 8'h7F); send(0, 8'h6C); send(0, 8'h01);
        send(0, 8'h7F); send(0, 8'h10);
        send(0, 8'hC0); send(0, 8'h3C); send(0, 8'h40);
        fe_a++;
        frame(0, 8'h55, 1'b0);
        line(0, 1'b0, 5 * CPB);
        line(0, 1'b1, 2 * CPB);
        chk("byte_out_after_ferr", 88'(a_byte_out), 88'(8'h40));
        chk("ferr_seen", 88'(fe_a), 88'(0));
        line(0, 1'b0, CPB / 4);
        line(0, 1'b1, 3 * CPB);
        chk("byte_out_after_glitch", 88'(a_byte_out), 88'(8'h40));
        send(0, 8'hA5);
        chk("byte_out_recover", 88'(a_byte_out), 88'(8'hA5));
        send(1, 8'h91); send(1, 8'h3C); send(1, 8'h64);
        ev(1, 7'd21, 1'b1, 7'd127, k(0), 8'd1, 7'd0);
        send(1, 8'h92); send(1, 8'h15); send(1, 8'h7F);
        ev(1, 7'd20, 1'b1, 7'd127, k(0), 8'd1, 7'd0);
        send(1, 8'h92); send(1, 8'h14); send(1, 8'h7F);
        line(0, 1'b0, 4 * CPB);
        reset = 1'b1;
        line(0, 1'b1, CPB);
        reset = 1'b0;
        line(0, 1'b1, 3 * CPB);
        chk("midrst_byte_out", 88'(a_byte_out), 88'(0));
        chk("midrst_keys_a", a_keys, 88'(0));
        chk("midrst_keys_b", b_keys, 88'(0));
        chk("midrst_key_count", 88'(a_key_count), 88'(0));
        chk("midrst_low_key", 88'(a_low_key), 88'(7'h7F));
        chk("q_byte_a_left", 88'(q_byte_a.size()), 88'(0));
        chk("q_ev_a_left", 88'(q_ev_a.size()), 88'(0));
        chk("q_ev_b_left", 88'(q_ev_b.size()), 88'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
